// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost-full/empty
// thresholds and a selectable first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, underflow_q;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          wr_acc, rd_acc;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Occupancy is the wrap-aware pointer difference; both pointers are registered,
  // so count and every flag settle in the cycle after the accepting edge.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr_en & ~wr_acc;
      underflow_q <= rd_en & ~rd_acc;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; zero while nothing is stored.
      assign rdata    = empty ? '0 : mem_q[rd_idx];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rd_idx];
        end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-mode and an FWFT instance share
// the same stimulus; FWFT outputs are only checked in the FWFT scenario.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;

  logic [7:0] rdata;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic [7:0] f_rdata;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int checks;
  int errors;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(f_rdata), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Apply one cycle of stimulus, then leave the bus idle; returns 1 ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    wdata = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_v;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wdata  = 8'h00;

    #2;
    check("rst_count",  32'(count), 0);
    check("rst_empty",  32'(empty), 1);
    check("rst_full",   32'(full), 0);
    check("rst_ae",     32'(almost_empty), 1);
    check("rst_af",     32'(almost_full), 0);
    check("rst_rvalid", 32'(rd_valid), 0);
    check("rst_rdata",  32'(rdata), 0);
    check("rst_ovf",    32'(overflow), 0);
    check("rst_unf",    32'(underflow), 0);
    #10 rst = 1'b0;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_af",    32'(almost_full), 32'(i >= 14));
      check("fill_ae",    32'(almost_empty), 32'(i <= 2));
      check("fill_ovf",   32'(overflow), 0);
    end
    check("fill_full", 32'(full), 1);

    // Rejected write on full
    step(1'b1, 8'hAA, 1'b0);
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    step(1'b0, 8'h00, 1'b0);
    check("ovf_clear", 32'(overflow), 0);

    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_data",  32'(rdata), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0);
    check("idle_valid", 32'(rd_valid), 0);
    check("idle_hold",  32'(rdata), 32'h10);
    check("idle_empty", 32'(empty), 1);

    // Underflow, then simultaneous write+read on empty
    step(1'b0, 8'h00, 1'b1);
    check("unf_pulse", 32'(underflow), 1);
    check("unf_valid", 32'(rd_valid), 0);
    check("unf_count", 32'(count), 0);
    check("unf_hold",  32'(rdata), 32'h10);
    step(1'b1, 8'h55, 1'b1);
    check("wr_rd_empty_count", 32'(count), 1);
    check("wr_rd_empty_unf",   32'(underflow), 1);
    check("wr_rd_empty_valid", 32'(rd_valid), 0);
    step(1'b0, 8'h00, 1'b1);
    check("rd55_data",  32'(rdata), 32'h55);
    check("rd55_valid", 32'(rd_valid), 1);
    check("rd55_count", 32'(count), 0);
    check("rd55_unf",   32'(underflow), 0);

    // Full FIFO with 20 cycles of simultaneous read/write across pointer wrap
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0);
      q.push_back(8'(8'h20 + i));
    end
    check("rw_full", 32'(full), 1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 8'(8'h30 + k), 1'b1);
      exp_v = q.pop_front();
      q.push_back(8'(8'h30 + k));
      check("rw_data",  32'(rdata), 32'(exp_v));
      check("rw_count", 32'(count), 16);
      check("rw_ovf",   32'(overflow), 0);
      check("rw_unf",   32'(underflow), 0);
    end
    while (q.size() > 0) begin
      step(1'b0, 8'h00, 1'b1);
      exp_v = q.pop_front();
      check("rw_drain", 32'(rdata), 32'(exp_v));
    end
    check("rw_empty", 32'(empty), 1);

    // FWFT behaviour
    check("fwft_pre_valid", 32'(f_rd_valid), 0);
    step(1'b1, 8'h3C, 1'b0);
    check("fwft_data",  32'(f_rdata), 32'h3C);
    check("fwft_valid", 32'(f_rd_valid), 1);
    step(1'b1, 8'h4D, 1'b0);
    check("fwft_head_hold", 32'(f_rdata), 32'h3C);
    step(1'b0, 8'h00, 1'b1);
    check("fwft_pop1", 32'(f_rdata), 32'h4D);
    check("fwft_pop1_valid", 32'(f_rd_valid), 1);
    step(1'b0, 8'h00, 1'b1);
    check("fwft_empty", 32'(f_empty), 1);
    check("fwft_empty_valid", 32'(f_rd_valid), 0);

    // Async reset mid-burst with count = 7
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("pre_rst_count", 32'(count), 7);
    check("pre_rst_data",  32'(rdata), 32'h60);
    check("pre_rst_valid", 32'(rd_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_valid", 32'(rd_valid), 0);
    check("arst_rdata", 32'(rdata), 0);
    check("arst_ae",    32'(almost_empty), 1);
    check("arst_f_count", 32'(f_count), 0);
    #1 rst = 1'b0;
    step(1'b1, 8'h99, 1'b0);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_fwft",  32'(f_rdata), 32'h99);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_data",  32'(rdata), 32'h99);
    check("post_rst_empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
